// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON block assembler and its pad unit.
package ascon_pack;

  localparam int unsigned DATA_W             = 256;
  localparam int unsigned MAX_RATE_BYTES     = 31;
  localparam int unsigned RATE_W             = $clog2(MAX_RATE_BYTES + 1);
  localparam int unsigned COUNT_W            = RATE_W;
  localparam int unsigned SIZE_W             = 8;
  localparam int unsigned BYTE_W             = 8;
  localparam logic [7:0]  ASCON_PAD_BYTE     = 8'h80;
  localparam logic [RATE_W-1:0] DEFAULT_RATE_BYTES = RATE_W'(8);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    OUT     = 2'd2
  } state_e;

  // Side-band description of the block currently presented downstream.
  typedef struct packed {
    logic [SIZE_W-1:0] size_r;
    logic              last;
    logic              padded;
  } blk_meta_t;

  // A programmed rate of zero selects the ASCON-128 default.
  function automatic logic [RATE_W-1:0] eff_rate(input logic [RATE_W-1:0] rate);
    return (rate == '0) ? DEFAULT_RATE_BYTES : rate;
  endfunction

endpackage

// File: rtl/ascon_pad_unit.sv
// Appends the ASCON pad byte after count_i message bytes and left-aligns the
// result inside a rate_bytes_i wide, LSB-aligned block.
module ascon_pad_unit
  import ascon_pack::*;
(
  input  logic [DATA_W-1:0]  sreg_i,
  input  logic [RATE_W-1:0]  rate_bytes_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic [DATA_W-1:0]  pad_c_o
);

  logic [RATE_W-1:0] gap_bytes;
  logic [7:0]        shamt;

  // count_i < rate_bytes_i always holds, so the gap never underflows.
  always_comb begin
    gap_bytes = rate_bytes_i - RATE_W'(count_i) - RATE_W'(1);
    shamt     = {gap_bytes, 3'b000};
    pad_c_o   = DATA_W'({sreg_i, ASCON_PAD_BYTE}) << shamt;
  end

endmodule

// File: rtl/ascon_block_assembler.sv
// Packs a byte stream big-endian into rate-sized, ASCON-padded blocks that are
// LSB-aligned in a 256-bit word, with valid/ready on both sides.
module ascon_block_assembler
  import ascon_pack::*;
(
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic [RATE_W-1:0]   rate_bytes_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BYTE_W-1:0]   in_byte_i,
  input  logic                in_last_i,
  input  logic                in_nodata_i,
  output logic                blk_valid_o,
  input  logic                blk_ready_i,
  output logic [DATA_W-1:0]   blk_data_o,
  output logic [SIZE_W-1:0]   blk_size_r_o,
  output logic                blk_last_o,
  output logic                blk_padded_o
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic               active_q, active_d;
  logic               pend_q, pend_d;
  blk_meta_t          meta_q, meta_d;
  logic               in_ready_q, in_ready_d;
  logic               blk_valid_q, blk_valid_d;

  logic [RATE_W-1:0]  cur_rate;
  logic [DATA_W-1:0]  pad_sreg;
  logic [COUNT_W-1:0] pad_count;
  logic [DATA_W-1:0]  pad_data;

  // Rate is taken from the port only for the first beat of a message.
  assign cur_rate = active_q ? rate_q : eff_rate(rate_bytes_i);

  // In OUT the unit builds the standalone pad block that follows a full final block.
  assign pad_sreg  = (state_q == OUT) ? '0 : sreg_q;
  assign pad_count = (state_q == OUT) ? '0 : count_q;

  ascon_pad_unit u_pad (
    .sreg_i       (pad_sreg),
    .rate_bytes_i (rate_q),
    .count_i      (pad_count),
    .pad_c_o      (pad_data)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sreg_d   = sreg_q;
    rate_d   = rate_q;
    active_d = active_q;
    pend_d   = pend_q;
    meta_d   = meta_q;

    unique case (state_q)
      COLLECT: begin
        if (in_valid_i) begin
          if (!active_q) begin
            rate_d = cur_rate;
          end
          active_d = !in_last_i;
          if (in_last_i && in_nodata_i) begin
            // Nothing to shift in; pad whatever has been collected so far.
            state_d = PAD;
          end else begin
            sreg_d  = DATA_W'({sreg_q, in_byte_i});
            count_d = count_q + COUNT_W'(1);
            if (count_q + COUNT_W'(1) == COUNT_W'(cur_rate)) begin
              state_d       = OUT;
              pend_d        = in_last_i;
              meta_d.last   = 1'b0;
              meta_d.padded = 1'b0;
            end else if (in_last_i) begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        sreg_d        = pad_data;
        state_d       = OUT;
        meta_d.last   = 1'b1;
        meta_d.padded = 1'b1;
      end
      OUT: begin
        if (blk_ready_i) begin
          if (pend_q) begin
            sreg_d        = pad_data;
            pend_d        = 1'b0;
            meta_d.last   = 1'b1;
            meta_d.padded = 1'b1;
          end else begin
            state_d       = COLLECT;
            count_d       = '0;
            sreg_d        = '0;
            meta_d.last   = 1'b0;
            meta_d.padded = 1'b0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    meta_d.size_r = (state_d == OUT) ? {rate_d, 3'b000} : '0;
    in_ready_d    = (state_d == COLLECT);
    blk_valid_d   = (state_d == OUT);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      sreg_q      <= '0;
      rate_q      <= DEFAULT_RATE_BYTES;
      active_q    <= 1'b0;
      pend_q      <= 1'b0;
      meta_q      <= '0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sreg_q      <= sreg_d;
      rate_q      <= rate_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      meta_q      <= meta_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign blk_valid_o  = blk_valid_q;
  assign blk_data_o   = sreg_q;
  assign blk_size_r_o = meta_q.size_r;
  assign blk_last_o   = meta_q.last;
  assign blk_padded_o = meta_q.padded;

endmodule

// File: tb/tb_ascon_block_assembler.sv
// Randomized and directed bench for ascon_block_assembler against a byte-list
// block model.
module tb_ascon_block_assembler;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic [4:0]   rate_bytes_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [7:0]   in_byte_i;
  logic         in_last_i;
  logic         in_nodata_i;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [255:0] blk_data_o;
  logic [7:0]   blk_size_r_o;
  logic         blk_last_o;
  logic         blk_padded_o;

  always #5 clock_i = ~clock_i;

  ascon_block_assembler dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .rate_bytes_i (rate_bytes_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_byte_i    (in_byte_i),
    .in_last_i    (in_last_i),
    .in_nodata_i  (in_nodata_i),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_data_o   (blk_data_o),
    .blk_size_r_o (blk_size_r_o),
    .blk_last_o   (blk_last_o),
    .blk_padded_o (blk_padded_o)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [7:0]   sz;
    logic         lst;
    logic         pd;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] msg[$];
  int n_chk = 0;
  int n_pass = 0;
  int ncyc = 0;
  int hs_cyc = 0;
  int lat_exp = 0;
  int rdy_mode = 1;
  int idle = 0;
  bit prev_valid = 1'b0;
  bit prev_stall = 1'b0;

  always @(posedge clock_i) ncyc <= ncyc + 1;

  // Byte k of a block sits at bits [8*rb-1-8k -: 8]; optional 0x80 follows the data.
  function automatic logic [255:0] pack_blk(input int rb, input logic [7:0] q[$], input bit pad);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < q.size(); k++) d[8*rb-1-8*k -: 8] = q[k];
    if (pad) d[8*rb-1-8*q.size() -: 8] = 8'h80;
    return d;
  endfunction

  function automatic exp_t mk(input int rb, input logic [7:0] q[$], input bit fin);
    exp_t e;
    e.d   = pack_blk(rb, q, fin);
    e.sz  = 8'(8 * rb);
    e.lst = fin;
    e.pd  = fin;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready",   256'(in_ready_o),   256'(1'b1));
    chk("rst_blk_valid",  256'(blk_valid_o),  256'(1'b0));
    chk("rst_blk_data",   blk_data_o,         256'(0));
    chk("rst_blk_size",   256'(blk_size_r_o), 256'(0));
    chk("rst_blk_last",   256'(blk_last_o),   256'(1'b0));
    chk("rst_blk_padded", 256'(blk_padded_o), 256'(1'b0));
  endtask

  // Output monitor and downstream ready driver.
  always @(negedge clock_i) begin
    bit r;
    exp_t e;
    if (!resetb_i) begin
      blk_ready_i = 1'b0;
      prev_valid  = 1'b0;
      prev_stall  = 1'b0;
      idle        = 0;
    end else begin
      if (blk_valid_o) begin
        idle = 0;
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_blk: got block %h, required none", blk_data_o);
        end else begin
          e = expq[0];
          chk("blk_data",   blk_data_o,         e.d);
          chk("blk_size_r", 256'(blk_size_r_o), 256'(e.sz));
          chk("blk_last",   256'(blk_last_o),   256'(e.lst));
          chk("blk_padded", 256'(blk_padded_o), 256'(e.pd));
        end
        chk("in_ready_busy", 256'(in_ready_o), 256'(1'b0));
        if (lat_exp != 0 && !prev_valid) begin
          chk("latency", 256'(ncyc - hs_cyc), 256'(lat_exp));
          lat_exp = 0;
        end
      end else begin
        if (prev_stall) begin
          n_chk++;
          $display("FAIL valid_dropped: got blk_valid 0, required 1");
        end
        if (expq.size() != 0) begin
          idle++;
          if (idle > 300) begin
            n_chk++;
            $display("FAIL blk_timeout: waited %0d cycles, required a block", idle);
            idle = 0;
            void'(expq.pop_front());
          end
        end
      end
      case (rdy_mode)
        1:       r = 1'b1;
        2:       r = 1'b0;
        default: r = ($urandom_range(0, 9) < 7);
      endcase
      blk_ready_i = r;
      prev_stall  = blk_valid_o && !r;
      prev_valid  = blk_valid_o;
      if (blk_valid_o && r && expq.size() != 0) void'(expq.pop_front());
    end
  end

  // Sends msg (empty => zero-length message); stop_after > 0 abandons it mid-way.
  task automatic send_msg(input int cfg, input bit rnd, input int lat, input int stop_after);
    int rb;
    int n;
    int i;
    int waitc;
    int beats;
    bit nod;
    logic [7:0] cur[$];
    rb    = (cfg == 0) ? 8 : cfg;
    n     = msg.size();
    nod   = (n == 0);
    beats = nod ? 1 : n;
    i     = 0;
    waitc = 0;
    while (i < beats) begin
      @(negedge clock_i);
      if (rnd && $urandom_range(0, 3) == 0) begin
        in_valid_i   = 1'b0;
        in_last_i    = 1'($urandom);
        in_nodata_i  = 1'($urandom);
        in_byte_i    = 8'($urandom);
        rate_bytes_i = 5'($urandom);
      end else begin
        in_valid_i   = 1'b1;
        in_nodata_i  = nod;
        in_byte_i    = nod ? 8'($urandom) : msg[i];
        in_last_i    = (i == beats - 1);
        rate_bytes_i = (i == 0) ? 5'(cfg) : 5'($urandom);
        if (in_ready_o) begin
          if (!nod) begin
            cur.push_back(msg[i]);
            if (cur.size() == rb) begin
              expq.push_back(mk(rb, cur, 1'b0));
              cur.delete();
            end
          end
          if (in_last_i) begin
            expq.push_back(mk(rb, cur, 1'b1));
            hs_cyc  = ncyc;
            lat_exp = lat;
          end
          i++;
          waitc = 0;
          if (i == stop_after) break;
        end
      end
      waitc++;
      if (waitc > 400) begin
        n_chk++;
        $display("FAIL in_ready_timeout: waited %0d cycles, required in_ready 1", waitc);
        break;
      end
    end
    @(negedge clock_i);
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    in_nodata_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((expq.size() != 0 || blk_valid_o) && w < 2000) begin
      @(negedge clock_i);
      w++;
    end
    if (w >= 2000) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d blocks outstanding, required 0", expq.size());
    end
  endtask

  task automatic set_msg_seq(input int first, input int len);
    msg.delete();
    for (int k = 0; k < len; k++) msg.push_back(8'(first + k));
  endtask

  initial begin
    logic [7:0] q[$];
    int w;
    resetb_i     = 1'b0;
    rate_bytes_i = '0;
    in_valid_i   = 1'b0;
    in_byte_i    = '0;
    in_last_i    = 1'b0;
    in_nodata_i  = 1'b0;
    blk_ready_i  = 1'b0;
    #12;
    check_reset_vals();
    @(negedge clock_i);
    resetb_i = 1'b1;

    // Hand-computed vectors pinning the block model.
    q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk("model_full8", pack_blk(8, q, 1'b0), 256'h0001020304050607);
    q = '{8'hAA, 8'hBB, 8'hCC};
    chk("model_part8", pack_blk(8, q, 1'b1), 256'hAABBCC8000000000);
    q.delete();
    chk("model_empty8", pack_blk(8, q, 1'b1), 256'h8000000000000000);
    q = '{8'h10, 8'h11, 8'h12, 8'h13};
    chk("model_part16", pack_blk(16, q, 1'b1), 256'h10111213800000000000000000000000);

    rdy_mode = 1;
    set_msg_seq(8'h00, 8);
    send_msg(8, 1'b0, 1, 0);
    drain();
    msg = '{8'hAA, 8'hBB, 8'hCC};
    send_msg(0, 1'b0, 2, 0);
    drain();
    set_msg_seq(8'h00, 20);
    send_msg(16, 1'b0, 2, 0);
    drain();
    msg.delete();
    send_msg(8, 1'b0, 2, 0);
    drain();

    // Downstream stall: block must hold and input must stay blocked.
    rdy_mode = 2;
    set_msg_seq(8'h40, 8);
    send_msg(8, 1'b0, 0, 0);
    w = 0;
    while (!blk_valid_o && w < 50) begin
      @(negedge clock_i);
      w++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_i);
      in_valid_i = 1'b1;
      in_byte_i  = 8'h5A;
      in_last_i  = 1'b0;
      chk("stall_in_ready", 256'(in_ready_o), 256'(1'b0));
    end
    @(negedge clock_i);
    in_valid_i = 1'b0;
    rdy_mode   = 1;
    drain();

    // Reset in the middle of a message discards the partial block.
    set_msg_seq(8'h01, 8);
    send_msg(8, 1'b0, 0, 3);
    #2;
    resetb_i = 1'b0;
    #1;
    check_reset_vals();
    expq.delete();
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b1;
    set_msg_seq(8'h11, 8);
    send_msg(8, 1'b0, 1, 0);
    drain();

    // Random rates, lengths, gaps, back-pressure.
    rdy_mode = 0;
    for (int m = 0; m < 40; m++) begin
      msg.delete();
      for (int k = 0, len = $urandom_range(0, 70); k < len; k++) msg.push_back(8'($urandom));
      send_msg($urandom_range(0, 31), 1'b1, 0, 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ascon_block_assembler.md
Name: ascon_block_assembler

Overview:
- Upstream feeder of the rate-masking/left-alignment stage.
- Accepts a byte stream (associated data or plaintext) over a valid/ready handshake and packs it big-endian into rate-sized blocks, LSB-aligned in a 256-bit word.
- Applies ASCON padding (0x80 then zeros) to the final block.
- Presents each block with its rate in bits, so the next stage can mask the block and shift it to the top of the state.

Parameters:
- DATA_W, 256, width of block output word (fixed by state-organizer interface)
- MAX_RATE_BYTES, 31, largest legal rate in bytes (r must fit the 8-bit size field)

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous active-low reset
- rate_bytes_i  in  5  block rate in bytes; sampled on first byte of each message
- in_valid_i  in  1  input byte valid
- in_ready_o  out  1  assembler can accept a byte this cycle
- in_byte_i  in  8  message byte, first byte = most significant
- in_last_i  in  1  qualifies the final byte of a message
- in_nodata_i  in  1  with valid+last: zero-length message, in_byte_i ignored
- blk_valid_o  out  1  block available
- blk_ready_i  in  1  downstream accepts block
- blk_data_o  out  256  block, LSB-aligned, valid bits [r-1:0], upper bits zero
- blk_size_r_o  out  8  r = 8*rate, in bits
- blk_last_o  out  1  block is final (padded) block of message
- blk_padded_o  out  1  block contains the padding byte

Behaviour:
- Reset (async, resetb_i=0): state=COLLECT, byte count=0, shift register=0.
  - Reset values: in_ready_o=1, blk_valid_o=0, blk_data_o=0, blk_size_r_o=0, blk_last_o=0, blk_padded_o=0.
  - Reset mid-message discards all partial data; no block is emitted.
- Rate latch: on the first accepted byte of a message, rate_bytes_i is latched. Value 0 maps to 8 (ASCON-128 default). Changes mid-message are ignored.
- FSM states:
  - COLLECT: in_ready_o=1. Each handshake shifts: sreg = (sreg<<8) | in_byte_i, count++.
    - count+1==rate and !last: go to OUT (last=0, padded=0).
    - count+1==rate and last: go to OUT (full block); pad_pending=1.
    - count+1<rate and last: go to PAD.
    - nodata+last: go to PAD with count=0, sreg unchanged (zero).
  - PAD: one cycle, no input accepted.
    - sreg = ((sreg<<8)|0x80) << 8*(rate-count-1).
    - Go to OUT with last=1, padded=1.
  - OUT: in_ready_o=0, blk_valid_o=1, outputs registered and stable until blk_ready_i.
    - On handshake with pad_pending=1: load sreg = 0x80 << 8*(rate-1), go to OUT again with last=1, padded=1, pad_pending=0.
    - On any other handshake: count=0, sreg=0, go to COLLECT.
- Latency:
  - Full block: blk_valid_o rises 1 cycle after the final byte handshake.
  - Partial/last block: 2 cycles (via PAD).
  - blk_ready_i held high gives 1 block per (rate+1) cycles max.
- blk_data_o bits above r are always zero. Byte k of the block sits at bits [r-1-8k : r-8-8k].
- Arithmetic: count is 5 bits and never exceeds rate-1 in COLLECT. Shift amounts are computed in 8-bit width. r = {rate,3'b000} (8 bits).
- A single buffer only: no byte accepted while a block is pending.
- in_last_i without in_valid_i is ignored.
- blk_valid_o never drops without a handshake.

Decomposition:
- Shared package (ascon_pack): state enum (COLLECT, PAD, OUT), ASCON_PAD_BYTE=8'h80, DEFAULT_RATE_BYTES=8, DATA_W=256.
- Sub-module ascon_pad_unit: combinational pad/shift of sreg given rate and count; reused by the downstream finalization path.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- rate=8, bytes 00..07, last on 07: block 0x0001020304050607 (r=64, last=0, padded=0), then block 0x8000000000000000 (last=1, padded=1).
- rate=8, bytes AA,BB,CC, last on CC: after 2 cycles, block 0xAABBCC8000000000, r=64, last=1.
- rate=16, 20 bytes 00..13, last on 13: first block 0x000102...0F (r=128); second block 0x10111213800000000000000000000000, last=1.
- Zero-length message (nodata+last, rate=8): single block 0x8000000000000000, last=1, padded=1.
- blk_ready_i held low for 10 cycles during OUT: blk_data_o stable, in_ready_o=0, in_valid_i bytes not consumed.
- resetb_i pulsed low after 3 of 8 bytes: outputs return to reset values immediately; next message of bytes 11..18 yields block 0x1112131415161718 with no stale data.
